shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand width; legal values are powers of 2 that are at least 4.
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port clk_en_i  input  1  clock enable; low freezes all registered state.
REQ-005 SHALL have port multiplicand_i  input  DATA_WIDTH  unsigned operand A.
REQ-006 SHALL have port multiplier_i  input  DATA_WIDTH  unsigned operand B.
REQ-007 SHALL have port addend_i  input  DATA_WIDTH  unsigned operand C.
REQ-008 SHALL have port data_valid_i  input  1  start request.
REQ-009 SHALL have port product_o  output  2*DATA_WIDTH  result A*B+C.
REQ-010 SHALL have port data_valid_o  output  1  one-cycle result-ready strobe.
REQ-011 SHALL have port idle_o  output  1  high when a new start is accepted or a result is being presented.

Function
REQ-012 SHALL compute product_o = A*B + C exactly, with no overflow. Max value 2^(2W) - 2^W fits in 2W bits.
REQ-013 SHALL implement FSM states IDLE, MULTIPLY and DONE.
REQ-014 IDLE behaviour:
- idle_o=1.
- On a clock-enabled edge with data_valid_i=1, SHALL latch A.
- SHALL load accumulator high half = C and low half = B.
- SHALL clear the iteration counter and go to MULTIPLY.
- Otherwise SHALL remain in IDLE.
REQ-015 MULTIPLY behaviour, per enabled cycle:
- If accumulator bit 0 = 1, SHALL add A to the high half with a (W+1)-bit carry.
- SHALL then shift {carry, high, low} right by 1.
- SHALL increment the counter.
- After the W-th iteration SHALL go to DONE.
REQ-016 DONE behaviour:
- data_valid_o=1 and idle_o=1 for exactly one enabled cycle.
- SHALL then go to IDLE.
REQ-017 data_valid_o and idle_o SHALL be decoded from state only.
- data_valid_o=0 in IDLE and MULTIPLY.
- idle_o=0 in MULTIPLY.
REQ-018 Latency: with start sampled at edge k, data_valid_o SHALL be high during cycle k+W+1, assuming clk_en_i stays high.
REQ-019 product_o SHALL be valid while data_valid_o=1 and SHALL hold its value until the next accepted start.
REQ-020 data_valid_i SHALL be ignored in MULTIPLY and DONE. Operand inputs SHALL be ignored except at the start edge.
REQ-021 Back-to-back: a start in the IDLE cycle immediately after DONE SHALL be accepted, giving a minimum period of W+2 cycles.
REQ-022 clk_en_i=0 SHALL freeze state, counter and accumulator, and SHALL extend latency by one cycle per stalled cycle.
REQ-023 A=0, B=0 or C=0 SHALL need no special casing and SHALL produce correct results.

Reset
REQ-024 rst_i=1 at a rising edge SHALL take priority over clk_en_i.
REQ-025 Reset SHALL force IDLE and clear the accumulator, counter and product_o to 0.
REQ-026 After reset: data_valid_o=0, idle_o=1, product_o=0.
REQ-027 Reset during MULTIPLY or DONE SHALL abort the operation, with no data_valid_o pulse for it.

Configuration
REQ-028 Macro EARLY_TERMINATION_EN SHALL control early termination.
REQ-029 With EARLY_TERMINATION_EN defined:
- In MULTIPLY, if all unconsumed multiplier bits are zero after the current step, SHALL shift the accumulator right by the remaining count in that same cycle.
- SHALL then go directly to DONE.
- MULTIPLY lasts max(1, index of B's MSB set + 1) cycles.
REQ-030 Without EARLY_TERMINATION_EN: MULTIPLY always lasts exactly W cycles. Results are identical in both builds.

Verification (W=16)
REQ-031 A=5, B=3, C=0, start at edge k -> product_o=15 with data_valid_o at k+17; with EARLY_TERMINATION_EN, at k+3.
REQ-032 A=0xFFFF, B=0xFFFF, C=0xFFFF -> product_o=0xFFFF0000, latency 17.
REQ-033 Divider inverse: A=142, B=7, C=6 -> product_o=1000 (0x3E8); with EARLY_TERMINATION_EN, data_valid_o at k+4.
REQ-034 Start A=9, B=9, then rst_i=1 at k+5 -> idle_o=1 and product_o=0 from k+6, with no data_valid_o pulse.
REQ-035 A=100, B=200, C=1, with clk_en_i=0 for 3 cycles during MULTIPLY -> product_o=20001 with data_valid_o at k+20.
REQ-036 data_valid_i held high continuously with new operands -> starts accepted only in IDLE, every W+2 cycles, each result correct.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - iterative unsigned A*B+C shift-add multiplier
// Optional macro EARLY_TERMINATION_EN: leave MULTIPLY as soon as the remaining multiplier bits are zero.
module shift_add_multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clk_en_i,
  input  logic [DATA_WIDTH-1:0]     multiplicand_i,
  input  logic [DATA_WIDTH-1:0]     multiplier_i,
  input  logic [DATA_WIDTH-1:0]     addend_i,
  input  logic                      data_valid_i,
  output logic [2*DATA_WIDTH-1:0]   product_o,
  output logic                      data_valid_o,
  output logic                      idle_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MULTIPLY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W:0]       sum;
  logic [2*W-1:0]   stepped;
  logic [2*W-1:0]   multiplied;
  logic             last_iter;

`ifdef EARLY_TERMINATION_EN
  logic [CNT_W:0]   consumed;
  logic [W-1:0]     rem_mask;
  logic [CNT_W-1:0] rem_cnt;
`endif

  always_comb begin
    // The high half keeps the carry so the shift never loses the top bit.
    sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    stepped = {sum, acc_q[W-1:1]};
`ifdef EARLY_TERMINATION_EN
    // After this step the unconsumed multiplier bits sit in the low W-1-cnt bits.
    consumed   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    rem_mask   = {W{1'b1}} >> consumed;
    rem_cnt    = CNT_W'(W - 1) - cnt_q;
    last_iter  = ((stepped[W-1:0] & rem_mask) == '0);
    multiplied = last_iter ? (stepped >> rem_cnt) : stepped;
`else
    last_iter  = (cnt_q == CNT_W'(W - 1));
    multiplied = stepped;
`endif

    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (data_valid_i) begin
          a_d     = multiplicand_i;
          acc_d   = {addend_i, multiplier_i};
          cnt_d   = '0;
          state_d = MULTIPLY;
        end
      end
      MULTIPLY: begin
        acc_d = multiplied;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The accumulator is untouched between DONE and the next start, so it doubles as the result.
  assign product_o    = acc_q;
  assign data_valid_o = (state_q == DONE);
  assign idle_o       = (state_q != MULTIPLY);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed table-driven bench for shift_add_multiplier (W=16)
module tb_shift_add_multiplier;

  localparam int W = 16;

  logic           clk;
  logic           rst_i;
  logic           clk_en_i;
  logic [W-1:0]   multiplicand_i;
  logic [W-1:0]   multiplier_i;
  logic [W-1:0]   addend_i;
  logic           data_valid_i;
  logic [2*W-1:0] product_o;
  logic           data_valid_o;
  logic           idle_o;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.DATA_WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clk_en_i       (clk_en_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .addend_i       (addend_i),
    .data_valid_i   (data_valid_i),
    .product_o      (product_o),
    .data_valid_o   (data_valid_o),
    .idle_o         (idle_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[11];
  vec_t bb[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int mult_cycles(input logic [W-1:0] b);
`ifdef EARLY_TERMINATION_EN
    int m;
    m = 1;
    for (int i = 0; i < W; i++) if (b[i]) m = i + 1;
    return m;
`else
    return W;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!data_valid_o && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    logic [2*W-1:0] held;
    multiplicand_i = v.a;
    multiplier_i   = v.b;
    addend_i       = v.c;
    data_valid_i   = 1'b1;
    step();
    multiplicand_i = W'($urandom);
    multiplier_i   = W'($urandom);
    addend_i       = W'($urandom);
    data_valid_i   = 1'($urandom_range(0, 1));
    check($sformatf("vec%0d idle_in_multiply", idx), 64'(idle_o), 64'd0);
    n = 0;
    while (!data_valid_o && n < 200) begin
      step();
      n++;
      data_valid_i = 1'($urandom_range(0, 1));
    end
    check($sformatf("vec%0d latency", idx), 64'(n + 1), 64'(mult_cycles(v.b) + 1));
    check($sformatf("vec%0d product", idx), 64'(product_o), 64'(v.exp));
    check($sformatf("vec%0d idle_in_done", idx), 64'(idle_o), 64'd1);
    held = product_o;
    data_valid_i = 1'b1;
    step();
    data_valid_i = 1'b0;
    check($sformatf("vec%0d strobe_one_cycle", idx), 64'(data_valid_o), 64'd0);
    check($sformatf("vec%0d idle_after_done", idx), 64'(idle_o), 64'd1);
    step();
    check($sformatf("vec%0d done_start_ignored", idx), 64'(idle_o), 64'd1);
    check($sformatf("vec%0d product_hold", idx), 64'(product_o), 64'(held));
  endtask

  initial begin
    int n;
    int seen;
    logic [2*W-1:0] held;

    vecs[0]  = '{16'd5,     16'd3,     16'd0,     32'd15};
    vecs[1]  = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  32'hFFFF0000};
    vecs[2]  = '{16'd142,   16'd7,     16'd6,     32'd1000};
    vecs[3]  = '{16'd0,     16'd1234,  16'd77,    32'd77};
    vecs[4]  = '{16'd1234,  16'd0,     16'd5,     32'd5};
    vecs[5]  = '{16'd0,     16'd0,     16'd0,     32'd0};
    vecs[6]  = '{16'd1,     16'hFFFF,  16'd0,     32'h0000FFFF};
    vecs[7]  = '{16'hFFFF,  16'd1,     16'hFFFF,  32'h0001FFFE};
    vecs[8]  = '{16'h8000,  16'h8000,  16'd0,     32'h40000000};
    vecs[9]  = '{16'h1234,  16'h5678,  16'd0,     32'h06260060};
    vecs[10] = '{16'd100,   16'd200,   16'd1,     32'd20001};

    bb[0] = '{16'd3,    16'd4,    16'd5,    32'd17};
    bb[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000};
    bb[2] = '{16'd7,    16'd0,    16'd9,    32'd9};

    // Reset with a pending start must win.
    rst_i          = 1'b1;
    clk_en_i       = 1'b1;
    data_valid_i   = 1'b1;
    multiplicand_i = 16'hABCD;
    multiplier_i   = 16'h1234;
    addend_i       = 16'h5555;
    step();
    step();
    rst_i        = 1'b0;
    data_valid_i = 1'b0;
    check("reset data_valid_o", 64'(data_valid_o), 64'd0);
    check("reset idle_o", 64'(idle_o), 64'd1);
    check("reset product_o", 64'(product_o), 64'd0);

    // A start with the clock disabled must not be taken.
    clk_en_i     = 1'b0;
    data_valid_i = 1'b1;
    step();
    step();
    data_valid_i = 1'b0;
    clk_en_i     = 1'b1;
    step();
    check("disabled_start idle_o", 64'(idle_o), 64'd1);
    check("disabled_start product_o", 64'(product_o), 64'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Three stalled cycles in MULTIPLY extend latency by three.
    multiplicand_i = 16'd100;
    multiplier_i   = 16'd200;
    addend_i       = 16'd1;
    data_valid_i   = 1'b1;
    step();
    data_valid_i = 1'b0;
    n = 0;
    repeat (2) begin step(); n++; end
    held     = product_o;
    clk_en_i = 1'b0;
    repeat (3) begin step(); n++; end
    check("stall product_frozen", 64'(product_o), 64'(held));
    check("stall idle_o", 64'(idle_o), 64'd0);
    check("stall data_valid_o", 64'(data_valid_o), 64'd0);
    clk_en_i = 1'b1;
    while (!data_valid_o && n < 200) begin step(); n++; end
    check("stall latency", 64'(n + 1), 64'(mult_cycles(16'd200) + 1 + 3));
    check("stall product", 64'(product_o), 64'd20001);
    step();

    // Reset mid-multiply with clock enable low aborts without a strobe.
    multiplicand_i = 16'd9;
    multiplier_i   = 16'd9;
    addend_i       = 16'd0;
    data_valid_i   = 1'b1;
    step();
    data_valid_i = 1'b0;
    step();
    step();
    check("abort pre_reset idle_o", 64'(idle_o), 64'd0);
    rst_i    = 1'b1;
    clk_en_i = 1'b0;
    step();
    rst_i    = 1'b0;
    clk_en_i = 1'b1;
    check("abort idle_o", 64'(idle_o), 64'd1);
    check("abort product_o", 64'(product_o), 64'd0);
    seen = 0;
    repeat (25) begin
      step();
      if (data_valid_o) seen++;
    end
    check("abort no_strobe", 64'(seen), 64'd0);

    // data_valid_i held high: starts only in IDLE, every M+2 cycles.
    multiplicand_i = bb[0].a;
    multiplier_i   = bb[0].b;
    addend_i       = bb[0].c;
    data_valid_i   = 1'b1;
    step();
    for (int j = 0; j < 3; j++) begin
      multiplicand_i = W'($urandom);
      multiplier_i   = W'($urandom);
      addend_i       = W'($urandom);
      wait_done(n);
      check($sformatf("b2b%0d latency", j), 64'(n + 1), 64'(mult_cycles(bb[j].b) + 1));
      check($sformatf("b2b%0d product", j), 64'(product_o), 64'(bb[j].exp));
      if (j < 2) begin
        multiplicand_i = bb[j+1].a;
        multiplier_i   = bb[j+1].b;
        addend_i       = bb[j+1].c;
      end else begin
        data_valid_i = 1'b0;
      end
      step();
      check($sformatf("b2b%0d idle_gap", j), 64'(idle_o), 64'd1);
      step();
      check($sformatf("b2b%0d restart", j), 64'(idle_o), (j < 2) ? 64'd0 : 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
